// File: rtl/dmem_arb_pkg.sv
// Shared state encoding and counter type for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int NUM_PORTS = 2;
    localparam int BCNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    typedef logic [BCNT_W-1:0] bcnt_t;

    // Ownership state that corresponds to a granted port index.
    function automatic arb_state_e own_state(input logic port);
        return port ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational 2-way picker: a lone requester always wins; ties are settled by
// ownership state, the burst count and the last-served pointer.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic       req0_i,
    input  logic       req1_i,
    input  arb_state_e state_i,
    input  bcnt_t      bcnt_i,
    input  logic       last_i,
    input  bcnt_t      max_burst_i,
    output logic       gnt0_o,
    output logic       gnt1_o
);

    logic tie_win1;

    // Burst count saturates at the limit, so ">=" means the owner has used its allowance.
    always_comb begin
        tie_win1 = 1'b0;
        case (state_i)
            ST_OWN0: tie_win1 = (bcnt_i >= max_burst_i);
            ST_OWN1: tie_win1 = (bcnt_i <  max_burst_i);
            default: tie_win1 = ~last_i;
        endcase
    end

    assign gnt0_o = req0_i & (~req1_i | ~tie_win1);
    assign gnt1_o = req1_i & (~req0_i | tie_win1);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the load/store unit (port 0) and a
// secondary requester (port 1) with round-robin arbitration and a bounded burst.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [AW-1:0] A0,
    input  logic [AW-1:0] A1,
    input  logic [DW-1:0] WD0,
    input  logic [DW-1:0] WD1,
    output logic          GNT0,
    output logic          GNT1,
    output logic          RVALID0,
    output logic          RVALID1,
    output logic [DW-1:0] RDATA0,
    output logic [DW-1:0] RDATA1,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_A,
    output logic [DW-1:0] MEM_WD,
    input  logic [DW-1:0] MEM_RD
);

    localparam bcnt_t MAX_B = bcnt_t'(MAX_BURST);

    arb_state_e           state_q, state_d;
    bcnt_t                bcnt_q, bcnt_d;
    logic                 last_q, last_d;
    logic [NUM_PORTS-1:0] gnt;
    logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
    logic [DW-1:0]        rdata0_q, rdata0_d;
    logic [DW-1:0]        rdata1_q, rdata1_d;
    logic                 req0_live, req1_live;

    // Requests are masked while reset is low so no grant or memory access leaks out.
    assign req0_live = REQ0 & RST_N;
    assign req1_live = REQ1 & RST_N;

    dmem_arb_pick u_pick (
        .req0_i      (req0_live),
        .req1_i      (req1_live),
        .state_i     (state_q),
        .bcnt_i      (bcnt_q),
        .last_i      (last_q),
        .max_burst_i (MAX_B),
        .gnt0_o      (gnt[0]),
        .gnt1_o      (gnt[1])
    );

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        last_d  = last_q;
        if (gnt == '0) begin
            state_d = ST_IDLE;
            bcnt_d  = '0;
        end else if (state_q == own_state(gnt[1])) begin
            bcnt_d = (bcnt_q >= MAX_B) ? MAX_B : bcnt_q + bcnt_t'(1);
        end else begin
            state_d = own_state(gnt[1]);
            bcnt_d  = bcnt_t'(1);
            last_d  = gnt[1];
        end
    end

    always_comb begin
        MEM_WE = 1'b0;
        MEM_A  = '0;
        MEM_WD = '0;
        if (gnt[0]) begin
            MEM_WE = WE0;
            MEM_A  = A0;
            MEM_WD = WD0;
        end else if (gnt[1]) begin
            MEM_WE = WE1;
            MEM_A  = A1;
            MEM_WD = WD1;
        end
    end

    // Read data is captured only on a granted read; otherwise the last value is held.
    always_comb begin
        rvalid_d[0] = gnt[0] & ~WE0;
        rvalid_d[1] = gnt[1] & ~WE1;
        rdata0_d    = rvalid_d[0] ? MEM_RD : rdata0_q;
        rdata1_d    = rvalid_d[1] ? MEM_RD : rdata1_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            bcnt_q   <= '0;
            last_q   <= 1'b1;
            rvalid_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign GNT0    = gnt[0];
    assign GNT1    = gnt[1];
    assign RVALID0 = rvalid_q[0];
    assign RVALID1 = rvalid_q[1];
    assign RDATA0  = rdata0_q;
    assign RDATA1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table vectors, directed corner sequences and random
// traffic checked against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;
    localparam int MEM_WORDS = 64;

    typedef struct packed {
        logic          r;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    typedef struct {
        req_t p0;
        req_t p1;
        logic eg0;
        logic eg1;
        logic ewe;
        logic erv0;
        logic erv1;
    } vec_t;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
    logic [AW-1:0] A0 = '0, A1 = '0;
    logic [DW-1:0] WD0 = '0, WD1 = '0;
    logic          GNT0, GNT1, RVALID0, RVALID1, MEM_WE;
    logic [DW-1:0] RDATA0, RDATA1, MEM_WD, MEM_RD;
    logic [AW-1:0] MEM_A;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .A0(A0), .A1(A1), .WD0(WD0), .WD1(WD1),
        .GNT0(GNT0), .GNT1(GNT1),
        .RVALID0(RVALID0), .RVALID1(RVALID1),
        .RDATA0(RDATA0), .RDATA1(RDATA1),
        .MEM_WE(MEM_WE), .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
    );

    always #5 CLK = ~CLK;

    // Data memory stand-in: combinational read, write on the rising edge.
    logic [DW-1:0] mem [MEM_WORDS];
    assign MEM_RD = mem[MEM_A[5:0]];
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'hA000 + i;
        forever begin
            @(posedge CLK);
            if (MEM_WE) mem[MEM_A[5:0]] <= MEM_WD;
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model: owner port (-1 none), length of current run, last served.
    int            m_owner, m_run, m_last;
    logic [DW-1:0] m_rdata [2];
    logic          m_rv    [2];
    logic [DW-1:0] ref_mem [MEM_WORDS];
    logic          s_gnt0, s_gnt1, s_we;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic req_t rq(input logic r, input logic w, input int a, input logic [DW-1:0] d);
        req_t x;
        x.r = r;
        x.w = w;
        x.a = AW'(a);
        x.d = d;
        return x;
    endfunction

    function automatic vec_t vt(input req_t p0, input req_t p1, input logic eg0, input logic eg1,
                                input logic ewe, input logic erv0, input logic erv1);
        vec_t v;
        v.p0 = p0; v.p1 = p1; v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe; v.erv0 = erv0; v.erv1 = erv1;
        return v;
    endfunction

    function automatic int model_pick(input logic r0, input logic r1);
        if (!r0 && !r1) return -1;
        if (r0 && !r1)  return 0;
        if (r1 && !r0)  return 1;
        if (m_owner < 0) return 1 - m_last;
        if (m_run < MAX_BURST) return m_owner;
        return 1 - m_owner;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_run = 0; m_last = 1;
        m_rdata[0] = '0; m_rdata[1] = '0;
        m_rv[0] = 1'b0;  m_rv[1] = 1'b0;
    endtask

    task automatic drive(input req_t p0, input req_t p1);
        REQ0 = p0.r; WE0 = p0.w; A0 = p0.a; WD0 = p0.d;
        REQ1 = p1.r; WE1 = p1.w; A1 = p1.a; WD1 = p1.d;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input req_t p0, input req_t p1, output int won);
        req_t pw;
        drive(p0, p1);
        #4;
        won = model_pick(p0.r, p1.r);
        s_gnt0 = GNT0; s_gnt1 = GNT1; s_we = MEM_WE;
        chk("gnt0", GNT0, won == 0);
        chk("gnt1", GNT1, won == 1);
        pw = (won == 1) ? p1 : p0;
        if (won < 0) begin
            chk("mem_we_idle", MEM_WE, 0);
            chk("mem_a_idle", MEM_A, 0);
            chk("mem_wd_idle", MEM_WD, 0);
        end else begin
            chk("mem_we", MEM_WE, pw.w);
            chk("mem_a", MEM_A, pw.a);
            chk("mem_wd", MEM_WD, pw.d);
        end
        m_rv[0] = 1'b0; m_rv[1] = 1'b0;
        if (won < 0) begin
            m_owner = -1; m_run = 0;
        end else begin
            if (m_owner == won) m_run = (m_run < MAX_BURST) ? m_run + 1 : MAX_BURST;
            else begin m_owner = won; m_run = 1; end
            m_last = won;
            if (pw.w) ref_mem[pw.a[5:0]] = pw.d;
            else begin m_rdata[won] = ref_mem[pw.a[5:0]]; m_rv[won] = 1'b1; end
        end
        @(posedge CLK);
        #1;
        chk("rvalid0", RVALID0, m_rv[0]);
        chk("rvalid1", RVALID1, m_rv[1]);
        chk("rdata0", RDATA0, m_rdata[0]);
        chk("rdata1", RDATA1, m_rdata[1]);
    endtask

    initial begin
        vec_t tbl [14];
        req_t idle, p0, p1;
        req_t pend [2];
        logic has [2];
        int   wait_c [2];
        int   max_wait;
        int   won;

        idle = '0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'hA000 + i;
        model_reset();

        for (int i = 0; i < 10; i++)
            tbl[i] = vt(rq(1, 0, 1, 0), rq(1, 0, 2, 0), (i < 4 || i >= 8), (i >= 4 && i < 8),
                        1'b0, (i < 4 || i >= 8), (i >= 4 && i < 8));
        tbl[10] = vt(idle, idle, 0, 0, 0, 0, 0);
        tbl[11] = vt(rq(1, 1, 5, 8), idle, 1, 0, 1, 0, 0);
        tbl[12] = vt(rq(1, 0, 5, 0), idle, 1, 0, 0, 1, 0);
        tbl[13] = vt(idle, idle, 0, 0, 0, 0, 0);

        // Reset held with both ports requesting: everything must stay quiet.
        RST_N = 1'b0;
        drive(rq(1, 1, 3, 55), rq(1, 0, 4, 66));
        repeat (2) begin
            @(negedge CLK);
            chk("rst_gnt0", GNT0, 0);
            chk("rst_gnt1", GNT1, 0);
            chk("rst_rvalid0", RVALID0, 0);
            chk("rst_rvalid1", RVALID1, 0);
            chk("rst_rdata0", RDATA0, 0);
            chk("rst_rdata1", RDATA1, 0);
            chk("rst_mem_we", MEM_WE, 0);
            chk("rst_mem_a", MEM_A, 0);
            chk("rst_mem_wd", MEM_WD, 0);
        end
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].p0, tbl[i].p1, won);
            chk("tbl_gnt0", s_gnt0, tbl[i].eg0);
            chk("tbl_gnt1", s_gnt1, tbl[i].eg1);
            chk("tbl_we", s_we, tbl[i].ewe);
            chk("tbl_rv0", RVALID0, tbl[i].erv0);
            chk("tbl_rv1", RVALID1, tbl[i].erv1);
            if (i == 12) chk("raw_rdata0", RDATA0, 8);
        end

        // Port 1 alone: ten writes then ten back-to-back reads.
        for (int a = 0; a < 10; a++) cycle(idle, rq(1, 1, a, a + 3), won);
        for (int a = 0; a < 10; a++) begin
            cycle(idle, rq(1, 0, a, 0), won);
            chk("p1_rvalid", RVALID1, 1);
            chk("p1_rdata", RDATA1, a + 3);
        end

        // Abort: port 1 asks during port 0 ownership, then withdraws.
        cycle(rq(1, 0, 6, 0), idle, won);
        cycle(rq(1, 0, 7, 0), rq(1, 1, 20, 32'hDEAD), won);
        chk("abort_gnt1", s_gnt1, 0);
        cycle(rq(1, 0, 8, 0), idle, won);
        chk("abort_gnt1b", s_gnt1, 0);
        cycle(idle, idle, won);
        chk("abort_mem", mem[20], 32'hA000 + 20);
        cycle(idle, rq(1, 0, 20, 0), won);

        // Random traffic with hold-until-grant requesters and occasional withdrawal.
        has[0] = 0; has[1] = 0; wait_c[0] = 0; wait_c[1] = 0; max_wait = 0;
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++)
                if (!has[n] && $urandom_range(0, 9) < 6) begin
                    has[n]  = 1;
                    pend[n] = rq(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, MEM_WORDS - 1)), $urandom);
                end
            p0 = has[0] ? pend[0] : idle;
            p1 = has[1] ? pend[1] : idle;
            cycle(p0, p1, won);
            for (int n = 0; n < 2; n++) begin
                if (won == n) begin has[n] = 0; wait_c[n] = 0; end
                else if (has[n]) begin
                    wait_c[n]++;
                    if (wait_c[n] > max_wait) max_wait = wait_c[n];
                    if ($urandom_range(0, 9) == 0) begin has[n] = 0; wait_c[n] = 0; end
                end
            end
        end
        chk("fair_wait", max_wait <= MAX_BURST, 1);

        // Reset falls while port 0 holds a read grant for A=2.
        cycle(rq(1, 0, 3, 0), idle, won);
        drive(rq(1, 0, 2, 0), idle);
        #4;
        chk("mr_gnt0", GNT0, 1);
        #1;
        RST_N = 1'b0;
        #1;
        chk("mr_gnt0_drop", GNT0, 0);
        chk("mr_mem_a", MEM_A, 0);
        chk("mr_rvalid0", RVALID0, 0);
        @(posedge CLK);
        #1;
        chk("mr_rvalid0_post", RVALID0, 0);
        chk("mr_rdata0", RDATA0, 0);
        drive(idle, idle);
        RST_N = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(rq(1, 0, i, 0), rq(1, 0, i + 10, 0), won);
            chk("mr_idle_gnt0", s_gnt0, i < 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
